// File: rtl/ssd_disp_scheduler_pkg.sv
// Shared encodings and ssd_disp field positions for the display scheduler.
package ssd_disp_scheduler_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_e;

  localparam int unsigned DISP_W          = 32;
  localparam int unsigned DIGIT_W         = 16;
  localparam int unsigned DISP_ACTIVE_BIT = 31;
  localparam int unsigned DISP_OWNER_LSB  = 16;

endpackage

// File: rtl/ssd_disp_scheduler_rr_pick.sv
// Combinational round-robin selector: first set request after 'last', wrapping.
module ssd_disp_scheduler_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  input  logic               exclude_en,
  input  logic [IDX_W-1:0]   exclude_idx,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [NUM_REQ-1:0] masked;
  logic [IDX_W-1:0]   cand;

  // Scan offsets from farthest to nearest so the nearest hit after 'last' wins.
  always_comb begin
    masked = req;
    if (exclude_en) begin
      masked = req & ~(NUM_REQ'(1) << exclude_idx);
    end
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = int'(NUM_REQ); k >= 1; k--) begin
      cand = IDX_W'((int'(last) + k) % int'(NUM_REQ));
      if (masked[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/ssd_disp_scheduler.sv
// Round-robin owner scheduler for the shared seven-segment display, with
// minimum hold time per owner and a lock to freeze the current owner.
module ssd_disp_scheduler
  import ssd_disp_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned CNT_W       = 26,
  parameter int unsigned IDX_W       = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DIGIT_W-1:0] data,
  input  logic                       lock,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       active,
  output logic [DISP_W-1:0]          ssd_disp
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NUM_REQ - 1);

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   last;      // winner of the latest pick; the owner while in SHOW

  logic [DIGIT_W-1:0] data_arr [NUM_REQ];
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               hold_done;
  logic               owner_req;
  logic [DISP_W-1:0]  disp_pick;
  logic [DISP_W-1:0]  disp_own;

  // Display word: active flag, owner index in the upper half, value in the lower half.
  function automatic logic [DISP_W-1:0] disp_word(input logic [IDX_W-1:0] i,
                                                  input logic [DIGIT_W-1:0] v);
    logic [DISP_W-1:0] w;
    w                            = '0;
    w[DISP_ACTIVE_BIT]           = 1'b1;
    w[DISP_OWNER_LSB +: IDX_W]   = i;
    w[DIGIT_W-1:0]               = v;
    return w;
  endfunction

  // Unpack the flat source bus into per-requester values.
  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      data_arr[i] = data[DIGIT_W*i +: DIGIT_W];
    end
  end

  assign hold_done = (cnt == HOLD_LAST);
  assign owner_req = req[last];
  assign disp_pick = disp_word(pick_idx, data_arr[pick_idx]);
  assign disp_own  = disp_word(last, data_arr[last]);

  // In SHOW the owner is excluded: either it dropped its request or its hold expired.
  ssd_disp_scheduler_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req         (req),
    .last        (last),
    .exclude_en  (state == ST_SHOW),
    .exclude_idx (last),
    .found       (pick_found),
    .idx         (pick_idx)
  );

  // Owner FSM, hold counter and registered display outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      last     <= LAST_RST;
      grant    <= '0;
      active   <= 1'b0;
      ssd_disp <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            state    <= ST_SHOW;
            last     <= pick_idx;
            cnt      <= '0;
            grant    <= NUM_REQ'(1) << pick_idx;
            active   <= 1'b1;
            ssd_disp <= disp_pick;
          end else begin
            grant    <= '0;
            active   <= 1'b0;
            ssd_disp <= '0;
          end
        end
        ST_SHOW: begin
          if (!owner_req) begin
            if (pick_found) begin
              last     <= pick_idx;
              cnt      <= '0;
              grant    <= NUM_REQ'(1) << pick_idx;
              ssd_disp <= disp_pick;
            end else begin
              state    <= ST_IDLE;
              cnt      <= '0;
              grant    <= '0;
              active   <= 1'b0;
              ssd_disp <= '0;
            end
          end else if (hold_done) begin
            if (lock) begin
              ssd_disp <= disp_own;
            end else if (pick_found) begin
              last     <= pick_idx;
              cnt      <= '0;
              grant    <= NUM_REQ'(1) << pick_idx;
              ssd_disp <= disp_pick;
            end else begin
              cnt      <= '0;
              ssd_disp <= disp_own;
            end
          end else begin
            cnt      <= cnt + CNT_W'(1);
            ssd_disp <= disp_own;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ssd_disp_scheduler.sv
// Directed table-driven bench for ssd_disp_scheduler (NUM_REQ=4, HOLD_CYCLES=4).
module tb_ssd_disp_scheduler;

  logic        clock;
  logic        reset;
  logic [3:0]  req;
  logic [63:0] data;
  logic        lock;
  logic [3:0]  grant;
  logic        active;
  logic [31:0] ssd_disp;

  int n_checks = 0;
  int n_fail   = 0;

  ssd_disp_scheduler #(
    .NUM_REQ     (4),
    .HOLD_CYCLES (4),
    .CNT_W       (3),
    .IDX_W       (2)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .data     (data),
    .lock     (lock),
    .grant    (grant),
    .active   (active),
    .ssd_disp (ssd_disp)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        rst;
    logic        lk;
    logic [3:0]  rq;
    logic [63:0] dat;
    int          rep;
    logic [3:0]  g;
    logic        act;
    logic [31:0] disp;
  } vec_t;

  vec_t vecs[$];

  localparam logic [63:0] D1 = 64'h7777_ABCD_5555_1234;
  localparam logic [63:0] D2 = 64'h7777_ABCD_00FF_1234;
  localparam logic [63:0] D3 = 64'h7777_ABCD_00FF_BEEF;

  function automatic vec_t mk(string name, logic rst, logic lk, logic [3:0] rq,
                              logic [63:0] dat, int rep, logic [3:0] g, logic act,
                              logic [31:0] disp);
    vec_t v;
    v.name = name; v.rst = rst; v.lk = lk; v.rq = rq; v.dat = dat;
    v.rep = rep; v.g = g; v.act = act; v.disp = disp;
    return v;
  endfunction

  task automatic check(string name, logic [3:0] eg, logic ea, logic [31:0] ed);
    n_checks++;
    if (grant !== eg || active !== ea || ssd_disp !== ed) begin
      n_fail++;
      $display("FAIL %s @%0t: got grant=%b active=%b ssd_disp=%h, expected grant=%b active=%b ssd_disp=%h",
               name, $time, grant, active, ssd_disp, eg, ea, ed);
    end
  endtask

  initial begin
    logic [3:0]  prev;
    logic [3:0]  exp_g;
    logic [31:0] exp_d;
    logic [15:0] exp_v [4];
    int          cyc;

    reset = 1'b1;
    req   = '0;
    data  = D1;
    lock  = 1'b0;

    vecs.push_back(mk("reset",          1, 0, 4'b0000, D1,  2, 4'b0000, 0, 32'h0000_0000));
    vecs.push_back(mk("idle_noreq",     0, 0, 4'b0000, D1, 10, 4'b0000, 0, 32'h0000_0000));
    vecs.push_back(mk("pick0",          0, 0, 4'b0101, D1,  1, 4'b0001, 1, 32'h8000_1234));
    vecs.push_back(mk("hold0",          0, 0, 4'b0101, D1,  3, 4'b0001, 1, 32'h8000_1234));
    vecs.push_back(mk("rr_to2",         0, 0, 4'b0101, D1,  1, 4'b0100, 1, 32'h8002_ABCD));
    vecs.push_back(mk("hold2",          0, 0, 4'b0101, D1,  3, 4'b0100, 1, 32'h8002_ABCD));
    vecs.push_back(mk("rr_back0",       0, 0, 4'b0101, D1,  1, 4'b0001, 1, 32'h8000_1234));
    vecs.push_back(mk("drop_to1",       0, 0, 4'b0010, D1,  1, 4'b0010, 1, 32'h8001_5555));
    vecs.push_back(mk("single_rehold",  0, 0, 4'b0010, D1, 11, 4'b0010, 1, 32'h8001_5555));
    vecs.push_back(mk("live_data",      0, 0, 4'b0010, D2,  1, 4'b0010, 1, 32'h8001_00FF));
    vecs.push_back(mk("lock_hold",      0, 1, 4'b1010, D2, 20, 4'b0010, 1, 32'h8001_00FF));
    vecs.push_back(mk("unlock_to3",     0, 0, 4'b1010, D2,  1, 4'b1000, 1, 32'h8003_7777));
    vecs.push_back(mk("own3_cnt1",      0, 0, 4'b1010, D2,  1, 4'b1000, 1, 32'h8003_7777));
    vecs.push_back(mk("drop_to0",       0, 0, 4'b0001, D3,  1, 4'b0001, 1, 32'h8000_BEEF));
    vecs.push_back(mk("all_drop",       0, 0, 4'b0000, D3,  1, 4'b0000, 0, 32'h0000_0000));
    vecs.push_back(mk("idle_lock",      0, 1, 4'b0000, D3,  3, 4'b0000, 0, 32'h0000_0000));
    vecs.push_back(mk("idle_lock_pick", 0, 1, 4'b0001, D2,  1, 4'b0001, 1, 32'h8000_1234));
    vecs.push_back(mk("drop_to2",       0, 0, 4'b0100, D2,  1, 4'b0100, 1, 32'h8002_ABCD));
    vecs.push_back(mk("rst_mid_show",   1, 0, 4'b1111, D2,  1, 4'b0000, 0, 32'h0000_0000));
    vecs.push_back(mk("first_after_rst",0, 0, 4'b1111, D2,  1, 4'b0001, 1, 32'h8000_1234));

    // Apply each row for 'rep' cycles, checking after every rising edge.
    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].rep; r++) begin
        @(negedge clock);
        reset = vecs[i].rst;
        lock  = vecs[i].lk;
        req   = vecs[i].rq;
        data  = vecs[i].dat;
        @(posedge clock);
        #1;
        check(vecs[i].name, vecs[i].g, vecs[i].act, vecs[i].disp);
      end
    end

    // With all four requesting, ownership rotates 1,2,3,0 every four cycles.
    exp_v[0] = 16'h1234;
    exp_v[1] = 16'h00FF;
    exp_v[2] = 16'hABCD;
    exp_v[3] = 16'h7777;
    for (int i = 1; i <= 4; i++) begin
      prev = grant;
      cyc  = 0;
      while (grant == prev && cyc < 10) begin
        @(posedge clock);
        #1;
        cyc++;
      end
      n_checks++;
      if (cyc != 4) begin
        n_fail++;
        $display("FAIL rotate_period_%0d: got %0d cycles to switch, expected 4", i, cyc);
      end
      exp_g = 4'b0001 << (i % 4);
      exp_d = {1'b1, 13'b0, 2'(i % 4), exp_v[i % 4]};
      check($sformatf("rotate_owner_%0d", i % 4), exp_g, 1'b1, exp_d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
